// File: rtl/tcp_session_pkg.sv
// Shared types for the multi-session TCP connection manager.
//   tcp_cmd_t    : command code driven to the TCP core
//   sess_state_t : per-session connection state
package tcp_session_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_OPEN   = 2'b00,
    CMD_LISTEN = 2'b01,
    CMD_CLOSE  = 2'b10
  } tcp_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_UP   = 3'd2,
    S_UP        = 3'd3,
    S_CLOSE_REQ = 3'd4,
    S_BACKOFF   = 3'd5,
    S_FAIL      = 3'd6
  } sess_state_t;

endpackage

// File: rtl/tcp_session_mgr_if.sv
// Command/event channel between the session manager and the TCP core.
//   req/cmd/sess/addr : command from manager (valid held until ack)
//   ack               : core accepts command (req & ack = transfer)
//   up/up_sess        : connection-established event
//   dn/dn_sess        : drop/refused event
// master = manager side, slave = TCP core side.
interface tcp_session_mgr_if
  import tcp_session_pkg::*;
#(
  parameter int unsigned NUM_SESS = 4,
  parameter int unsigned ADDR_W   = 16
);

  localparam int unsigned SESS_W = (NUM_SESS > 1) ? $clog2(NUM_SESS) : 1;

  logic              req;
  tcp_cmd_t          cmd;
  logic [SESS_W-1:0] sess;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic              up;
  logic [SESS_W-1:0] up_sess;
  logic              dn;
  logic [SESS_W-1:0] dn_sess;

  modport master (
    output req, cmd, sess, addr,
    input  ack, up, up_sess, dn, dn_sess
  );

  modport slave (
    input  req, cmd, sess, addr,
    output ack, up, up_sess, dn, dn_sess
  );

endinterface

// File: rtl/tcp_session_fsm.sv
// One TCP session: connect/reconnect FSM with connect timeout, backoff
// timer and consecutive-failure counter.
//   clk, rst    : clock, synchronous active-high reset
//   connect     : session enable (level)
//   mode        : 0 initiator, 1 acceptor; captured when leaving IDLE
//   recon_int   : backoff interval in ticks (0 behaves as 1)
//   tick        : prescaler strobe
//   granted     : this session owns the registered channel command
//   xfer        : this session's command was accepted
//   up, dn      : demuxed core events for this session
//   req_c/cmd_c : combinational request to the arbiter
//   connected   : registered, session in UP
//   failed      : registered, session in FAIL
module tcp_session_fsm
  import tcp_session_pkg::*;
#(
  parameter int unsigned RECON_W   = 8,
  parameter int unsigned CONN_TO   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               connect,
  input  logic               mode,
  input  logic [RECON_W-1:0] recon_int,
  input  logic               tick,
  input  logic               granted,
  input  logic               xfer,
  input  logic               up,
  input  logic               dn,
  output logic               req_c,
  output tcp_cmd_t           cmd_c,
  output logic               connected,
  output logic               failed
);

  localparam int unsigned TO_W  = $clog2(CONN_TO + 1);
  localparam int unsigned TMR_W = (RECON_W > TO_W) ? RECON_W : TO_W;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sess_state_t        state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [RTY_W-1:0]   retry, retry_nxt;
  logic               mode_q, mode_nxt;
  logic               enter_bo;

  // State, timer, retry count and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      retry     <= '0;
      mode_q    <= 1'b0;
      connected <= 1'b0;
      failed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      retry     <= retry_nxt;
      mode_q    <= mode_nxt;
      connected <= (state_nxt == S_UP);
      failed    <= (state_nxt == S_FAIL);
    end
  end

  // Next-state and request logic
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    retry_nxt = retry;
    mode_nxt  = mode_q;
    req_c     = 1'b0;
    cmd_c     = CMD_OPEN;
    enter_bo  = 1'b0;

    case (state)
      S_IDLE: begin
        if (connect) begin
          state_nxt = S_REQ;
          mode_nxt  = mode;
        end
      end
      S_REQ: begin
        // Once granted the command is committed; only an ungranted request is withdrawn.
        req_c = connect;
        cmd_c = mode_q ? CMD_LISTEN : CMD_OPEN;
        if (xfer) begin
          state_nxt = S_WAIT_UP;
          tmr_nxt   = TMR_W'(CONN_TO);
        end else if (!granted && !connect) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_UP: begin
        if (dn) begin
          enter_bo = 1'b1;
        end else if (!connect) begin
          state_nxt = S_CLOSE_REQ;
        end else if (up) begin
          state_nxt = S_UP;
          retry_nxt = '0;
        end else if (!mode_q && tick) begin
          if (tmr <= TMR_W'(1)) enter_bo = 1'b1;
          else                  tmr_nxt  = tmr - TMR_W'(1);
        end
      end
      S_UP: begin
        if (dn)            enter_bo  = 1'b1;
        else if (!connect) state_nxt = S_CLOSE_REQ;
      end
      S_CLOSE_REQ: begin
        req_c = 1'b1;
        cmd_c = CMD_CLOSE;
        if (xfer) state_nxt = S_IDLE;
      end
      S_BACKOFF: begin
        if (!connect) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (tmr <= TMR_W'(1)) state_nxt = S_REQ;
          else                  tmr_nxt   = tmr - TMR_W'(1);
        end
      end
      S_FAIL: begin
        if (!connect) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A failure either schedules a retry or, once the budget is spent, parks in FAIL
    if (enter_bo) begin
      if (retry == RTY_W'(MAX_RETRY)) begin
        state_nxt = S_FAIL;
      end else begin
        state_nxt = S_BACKOFF;
        retry_nxt = retry + RTY_W'(1);
        tmr_nxt   = (recon_int == '0) ? TMR_W'(1) : TMR_W'(recon_int);
      end
    end

    if (state_nxt == S_IDLE) retry_nxt = '0;
  end

endmodule

// File: rtl/tcp_session_mgr.sv
// Multi-session TCP connection manager: NUM_SESS session FSMs sharing one
// round-robin arbitrated command channel to the TCP core.
//   clk, rst     : clock, synchronous active-high reset
//   connect_i    : per-session enable
//   mode_i       : per-session 0 initiator / 1 acceptor
//   host_addr_i  : per-session remote/listen address
//   recon_int_i  : per-session backoff interval in ticks
//   tcp          : command channel and core events (master side)
//   connected_o  : sessions in UP
//   failed_o     : sessions in FAIL
module tcp_session_mgr
  import tcp_session_pkg::*;
#(
  parameter int unsigned NUM_SESS  = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RECON_W   = 8,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned CONN_TO   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SESS-1:0]         connect_i,
  input  logic [NUM_SESS-1:0]         mode_i,
  input  logic [NUM_SESS*ADDR_W-1:0]  host_addr_i,
  input  logic [NUM_SESS*RECON_W-1:0] recon_int_i,
  tcp_session_mgr_if.master           tcp,
  output logic [NUM_SESS-1:0]         connected_o,
  output logic [NUM_SESS-1:0]         failed_o
);

  localparam int unsigned SESS_W = (NUM_SESS > 1) ? $clog2(NUM_SESS) : 1;
  localparam int unsigned PRE_W  = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    pre_cnt;
  logic                tick_c;
  logic [NUM_SESS-1:0] up_vec_c, dn_vec_c, granted_c, xfer_c, req_vec_c;
  tcp_cmd_t            cmd_arr_c  [NUM_SESS];
  logic [ADDR_W-1:0]   addr_arr_c [NUM_SESS];
  logic [SESS_W-1:0]   rr_ptr, win_c, ptr_nxt_c;
  logic                any_c;

  // Free-running tick prescaler
  assign tick_c = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         pre_cnt <= '0;
    else if (tick_c) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Per-session event demux and grant/transfer decode
  always_comb begin
    up_vec_c  = '0;
    dn_vec_c  = '0;
    granted_c = '0;
    for (int unsigned i = 0; i < NUM_SESS; i++) begin
      up_vec_c[i]  = tcp.up  && (tcp.up_sess == SESS_W'(i));
      dn_vec_c[i]  = tcp.dn  && (tcp.dn_sess == SESS_W'(i));
      granted_c[i] = tcp.req && (tcp.sess    == SESS_W'(i));
    end
    xfer_c = granted_c & {NUM_SESS{tcp.ack}};
  end

  for (genvar g = 0; g < NUM_SESS; g++) begin : g_sess
    assign addr_arr_c[g] = host_addr_i[g*ADDR_W +: ADDR_W];

    tcp_session_fsm #(
      .RECON_W   (RECON_W),
      .CONN_TO   (CONN_TO),
      .MAX_RETRY (MAX_RETRY)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .connect   (connect_i[g]),
      .mode      (mode_i[g]),
      .recon_int (recon_int_i[g*RECON_W +: RECON_W]),
      .tick      (tick_c),
      .granted   (granted_c[g]),
      .xfer      (xfer_c[g]),
      .up        (up_vec_c[g]),
      .dn        (dn_vec_c[g]),
      .req_c     (req_vec_c[g]),
      .cmd_c     (cmd_arr_c[g]),
      .connected (connected_o[g]),
      .failed    (failed_o[g])
    );
  end

  // Round-robin pick: first requester at or after rr_ptr
  always_comb begin
    win_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 0; k < NUM_SESS; k++) begin
      logic [SESS_W-1:0] sel;
      sel = SESS_W'((32'(rr_ptr) + k) % NUM_SESS);
      if (!any_c && req_vec_c[sel]) begin
        any_c = 1'b1;
        win_c = sel;
      end
    end
    ptr_nxt_c = SESS_W'((32'(tcp.sess) + 32'd1) % NUM_SESS);
  end

  // Registered grant; command fields frozen until the core acks
  always_ff @(posedge clk) begin
    if (rst) begin
      tcp.req  <= 1'b0;
      tcp.cmd  <= CMD_OPEN;
      tcp.sess <= '0;
      tcp.addr <= '0;
      rr_ptr   <= '0;
    end else if (tcp.req) begin
      if (tcp.ack) begin
        tcp.req <= 1'b0;
        rr_ptr  <= ptr_nxt_c;
      end
    end else if (any_c) begin
      tcp.req  <= 1'b1;
      tcp.cmd  <= cmd_arr_c[win_c];
      tcp.sess <= win_c;
      tcp.addr <= addr_arr_c[win_c];
    end
  end

endmodule

// File: tb/tb_tcp_session_mgr.sv
// Self-checking bench for tcp_session_mgr: per-cycle vector tables for the
// handshake sequences, hand-written sequences for timer-driven behaviour.
module tb_tcp_session_mgr;
  import tcp_session_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned RW = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned CT = 16;
  localparam int unsigned MR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     connect;
  logic [NS-1:0]     mode;
  logic [NS*AW-1:0]  host_addr;
  logic [NS*RW-1:0]  recon_int;
  logic [NS-1:0]     connected;
  logic [NS-1:0]     failed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcp_session_mgr_if #(.NUM_SESS(NS), .ADDR_W(AW)) tcp ();

  tcp_session_mgr #(
    .NUM_SESS (NS), .ADDR_W (AW), .RECON_W (RW),
    .TICK_DIV (TD), .CONN_TO (CT), .MAX_RETRY (MR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .connect_i   (connect),
    .mode_i      (mode),
    .host_addr_i (host_addr),
    .recon_int_i (recon_int),
    .tcp         (tcp),
    .connected_o (connected),
    .failed_o    (failed)
  );

  typedef struct {
    logic [3:0]  connect;
    logic        ack;
    logic        up;
    logic [1:0]  up_sess;
    logic        dn;
    logic [1:0]  dn_sess;
    logic        exp_req;
    logic [1:0]  exp_cmd;
    logic [1:0]  exp_sess;
    logic [15:0] exp_addr;
    logic [3:0]  exp_conn;
    logic [3:0]  exp_fail;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] c, input logic a, input logic u,
                              input logic [1:0] us, input logic d, input logic [1:0] ds,
                              input logic er, input logic [1:0] ec, input logic [1:0] es,
                              input logic [15:0] ea, input logic [3:0] econ,
                              input logic [3:0] ef);
    vec_t r;
    r.connect = c;  r.ack = a; r.up = u; r.up_sess = us; r.dn = d; r.dn_sess = ds;
    r.exp_req = er; r.exp_cmd = ec; r.exp_sess = es; r.exp_addr = ea;
    r.exp_conn = econ; r.exp_fail = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    total++;
    if (val < lo || val > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; connect = '0;
    tcp.ack = 1'b0; tcp.up = 1'b0; tcp.dn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      connect     = vq[i].connect;
      tcp.ack     = vq[i].ack;
      tcp.up      = vq[i].up;
      tcp.up_sess = vq[i].up_sess;
      tcp.dn      = vq[i].dn;
      tcp.dn_sess = vq[i].dn_sess;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d] req", tag, i), 32'(tcp.req), 32'(vq[i].exp_req));
      if (vq[i].exp_req) begin
        chk($sformatf("%s[%0d] cmd", tag, i), 32'(tcp.cmd), 32'(vq[i].exp_cmd));
        chk($sformatf("%s[%0d] sess", tag, i), 32'(tcp.sess), 32'(vq[i].exp_sess));
        chk($sformatf("%s[%0d] addr", tag, i), 32'(tcp.addr), 32'(vq[i].exp_addr));
      end
      chk($sformatf("%s[%0d] conn", tag, i), 32'(connected), 32'(vq[i].exp_conn));
      chk($sformatf("%s[%0d] fail", tag, i), 32'(failed), 32'(vq[i].exp_fail));
    end
    @(negedge clk);
    tcp.ack = 1'b0; tcp.up = 1'b0; tcp.dn = 1'b0;
    vq.delete();
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      if (tcp.req) break;
      n++;
    end
    chk({name, " req"}, 32'(tcp.req), 32'd1);
  endtask

  task automatic ack_xfer(input string name);
    @(negedge clk);
    tcp.ack = 1'b1;
    @(posedge clk); #1;
    chk({name, " req after ack"}, 32'(tcp.req), 32'd0);
    @(negedge clk);
    tcp.ack = 1'b0;
  endtask

  task automatic count_reqs(input string name, input int cycles);
    int n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (tcp.req) n++;
    end
    chk({name, " quiet"}, 32'(n), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_dn;
    rst = 1'b1; connect = '0; mode = '0; host_addr = '0; recon_int = '0;
    tcp.ack = 1'b0; tcp.up = 1'b0; tcp.up_sess = '0; tcp.dn = 1'b0; tcp.dn_sess = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req",  32'(tcp.req),  32'd0);
    chk("reset cmd",  32'(tcp.cmd),  32'd0);
    chk("reset sess", 32'(tcp.sess), 32'd0);
    chk("reset addr", 32'(tcp.addr), 32'd0);
    chk("reset conn", 32'(connected), 32'd0);
    chk("reset fail", 32'(failed),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Initiator on session 0: OPEN two cycles after connect, then up
    host_addr[0*AW +: AW] = 16'h1234;
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 2'b00, 0, 16'h1234, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0001, 1, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0001, 0, 1, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0001, 4'b0000));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0001, 4'b0000));
    run_table("t1");

    // Acceptor on session 2: LISTEN, no timeout over 100 ticks, then up
    do_reset();
    mode = 4'b0100;
    host_addr[2*AW +: AW] = 16'hABCD;
    connect = 4'b0100;
    wait_req("t2", 10);
    chk("t2 cmd",  32'(tcp.cmd),  32'(CMD_LISTEN));
    chk("t2 sess", 32'(tcp.sess), 32'd2);
    chk("t2 addr", 32'(tcp.addr), 32'hABCD);
    ack_xfer("t2");
    count_reqs("t2 100 ticks", 100 * TD);
    chk("t2 conn before up", 32'(connected), 32'd0);
    chk("t2 fail before up", 32'(failed),    32'd0);
    @(negedge clk);
    tcp.up = 1'b1; tcp.up_sess = 2'd2;
    @(posedge clk); #1;
    chk("t2 conn", 32'(connected), 32'b0100);
    @(negedge clk);
    tcp.up = 1'b0;

    // Initiator refused every time: 3 retries spaced by 2 ticks, then FAIL
    do_reset();
    mode = 4'b0000;
    recon_int[0*RW +: RW] = 8'd2;
    host_addr[0*AW +: AW] = 16'h0042;
    connect = 4'b0001;
    t_dn = 0;
    for (int r = 0; r < 4; r++) begin
      wait_req($sformatf("t3 try%0d", r), 40);
      if (r > 0) chk_rng($sformatf("t3 gap%0d", r), cyc - t_dn, 6, 9);
      chk($sformatf("t3 cmd%0d", r),  32'(tcp.cmd),  32'(CMD_OPEN));
      chk($sformatf("t3 sess%0d", r), 32'(tcp.sess), 32'd0);
      ack_xfer($sformatf("t3 try%0d", r));
      @(negedge clk);
      tcp.dn = 1'b1; tcp.dn_sess = 2'd0;
      @(posedge clk); #1;
      t_dn = cyc;
      chk($sformatf("t3 fail%0d", r), 32'(failed), (r == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
      tcp.dn = 1'b0;
    end
    count_reqs("t3 after fail", 30);
    chk("t3 fail held", 32'(failed), 32'd1);
    @(negedge clk);
    connect = 4'b0000;
    @(posedge clk); #1;
    chk("t3 fail cleared", 32'(failed), 32'd0);

    // All four sessions at once, each ack stalled: grants 0..3 with stable fields
    do_reset();
    mode = 4'b0000;
    for (int s = 0; s < 4; s++) host_addr[s*AW +: AW] = 16'h1000 + 16'(s);
    vq.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    for (int s = 0; s < 4; s++) begin
      vq.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 1, 2'b00, 2'(s), 16'h1000 + 16'(s), 4'b0000, 4'b0000));
      vq.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 1, 2'b00, 2'(s), 16'h1000 + 16'(s), 4'b0000, 4'b0000));
      vq.push_back(mk(4'b1111, 0, 0, 0, 0, 0, 1, 2'b00, 2'(s), 16'h1000 + 16'(s), 4'b0000, 4'b0000));
      vq.push_back(mk(4'b1111, 1, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    end
    run_table("t4");

    // Same-cycle up+down on session 1 backs off; later drop in UP sends one CLOSE
    do_reset();
    mode = 4'b0000;
    recon_int[1*RW +: RW] = 8'd1;
    host_addr[1*AW +: AW] = 16'h5555;
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, 2'b00, 1, 16'h5555, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0010, 1, 0, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    vq.push_back(mk(4'b0010, 0, 1, 1, 1, 1, 0, 2'b00, 0, 16'h0000, 4'b0000, 4'b0000));
    run_table("t5");
    wait_req("t5 retry", 20);
    chk("t5 retry cmd",  32'(tcp.cmd),  32'(CMD_OPEN));
    chk("t5 retry sess", 32'(tcp.sess), 32'd1);
    ack_xfer("t5 retry");
    @(negedge clk);
    tcp.up = 1'b1; tcp.up_sess = 2'd1;
    @(posedge clk); #1;
    chk("t5 conn", 32'(connected), 32'b0010);
    @(negedge clk);
    tcp.up = 1'b0;
    connect = 4'b0000;
    @(posedge clk); #1;
    chk("t5 conn dropped", 32'(connected), 32'd0);
    wait_req("t5 close", 10);
    chk("t5 close cmd",  32'(tcp.cmd),  32'(CMD_CLOSE));
    chk("t5 close sess", 32'(tcp.sess), 32'd1);
    chk("t5 close addr", 32'(tcp.addr), 32'h5555);
    ack_xfer("t5 close");
    count_reqs("t5 after close", 30);

    // Reset while a LISTEN for session 3 is stalled
    do_reset();
    mode = 4'b1000;
    host_addr[3*AW +: AW] = 16'h7777;
    connect = 4'b1000;
    wait_req("t6", 10);
    chk("t6 stalled cmd",  32'(tcp.cmd),  32'(CMD_LISTEN));
    chk("t6 stalled sess", 32'(tcp.sess), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6 req",  32'(tcp.req),  32'd0);
    chk("t6 cmd",  32'(tcp.cmd),  32'd0);
    chk("t6 sess", 32'(tcp.sess), 32'd0);
    chk("t6 addr", 32'(tcp.addr), 32'd0);
    chk("t6 conn", 32'(connected), 32'd0);
    chk("t6 fail", 32'(failed),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    connect = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
